// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
//
// Write-only I2C target for the three-byte register write format
// [DEV_ADDR+W, SUB_ADDR, DATA]. SCL and SDA are oversampled on CLOCK,
// which must run at least 8x the SCL frequency. START and STOP are
// detected, the 7-bit device address is matched, and each accepted byte is
// ACKed. Each completed data byte produces a one-cycle write strobe that
// carries the sub-address and the data.
//
// Optional build macro:
//   I2C_TARGET_AUTO_INC_EN - after each data byte, return to DATA and
//                            increment the sub-address (wraps 0xFF->0x00),
//                            so burst writes are accepted. When the macro
//                            is not defined, bytes after the first data byte
//                            are not ACKed and produce no strobe.
//
// Parameters:
//   DEV_ADDR     7-bit address this target answers to (default 7'h1A).
//   SYNC_STAGES  depth of the SCL/SDA input synchronisers (>= 2).
//
// Ports:
//   CLOCK      in   system clock
//   RESET      in   asynchronous active-low reset
//   I2C_SCLK   in   bus clock (never stretched)
//   I2C_SDAT   io   bus data, open drain (0 or Z only)
//   WR_ADDR    out  sub-address of the last accepted write
//   WR_DATA    out  data of the last accepted write
//   WR_STB     out  one-CLOCK pulse when WR_ADDR/WR_DATA are updated
//   BUSY       out  addressed transfer in progress (address match to STOP)
//   ERR        out  sticky error: read request to this address, or STOP
//                   before a data byte completed; cleared by next START
// ---------------------------------------------------------------------------
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       WR_STB,
    output logic       BUSY,
    output logic       ERR
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // Input synchronisers. They are preset to 1 so that reset looks like an
    // idle bus and no false START/STOP can be seen on exit from reset.
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], I2C_SDAT};
            scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    // Bus conditions require SCL high in both samples, so an SDA change that
    // coincides with an SCL edge in the synchronised view is not misread.
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    state_t     state_reg,   state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg,   shift_next;
    logic [7:0] sub_reg,     sub_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       wr_stb_reg,  wr_stb_next;
    logic       busy_reg,    busy_next;
    logic       err_reg,     err_next;
    logic       sda_oe_reg,  sda_oe_next;
    // Set once a data byte has been strobed in the current transfer, so a
    // STOP at a byte boundary after a burst is not flagged as an error.
    logic       wr_done_reg, wr_done_next;

    logic [7:0] byte_in;
    assign byte_in = {shift_reg[6:0], sda_s};

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            sub_reg     <= 8'h00;
            wr_addr_reg <= 8'h00;
            wr_data_reg <= 8'h00;
            wr_stb_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            sda_oe_reg  <= 1'b0;
            wr_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            sub_reg     <= sub_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            wr_stb_reg  <= wr_stb_next;
            busy_reg    <= busy_next;
            err_reg     <= err_next;
            sda_oe_reg  <= sda_oe_next;
            wr_done_reg <= wr_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        sub_next     = sub_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        wr_stb_next  = 1'b0;
        busy_next    = busy_reg;
        err_next     = err_reg;
        sda_oe_next  = sda_oe_reg;
        wr_done_next = wr_done_reg;

        if (start_det) begin
            // START or repeated START: always restart address reception.
            state_next   = ADDR;
            bit_cnt_next = 3'd0;
            err_next     = 1'b0;
            busy_next    = 1'b0;
            sda_oe_next  = 1'b0;
            wr_done_next = 1'b0;
        end else if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = 3'd0;
            busy_next    = 1'b0;
            sda_oe_next  = 1'b0;
            if ((state_reg == SUB) || (state_reg == SUB_ACK) ||
                ((state_reg == DATA) && (!wr_done_reg || (bit_cnt_reg != 3'd0)))) begin
                err_next = 1'b1;
            end
        end else begin
            case (state_reg)
                ADDR, SUB, DATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = 3'(bit_cnt_reg + 3'd1);
                        if (bit_cnt_reg == 3'd7) begin
                            case (state_reg)
                                ADDR: begin
                                    if (byte_in[7:1] != DEV_ADDR) begin
                                        state_next = IGNORE;
                                    end else if (byte_in[0]) begin
                                        state_next = IGNORE;
                                        err_next   = 1'b1;
                                    end else begin
                                        state_next = ADDR_ACK;
                                        busy_next  = 1'b1;
                                    end
                                end
                                SUB: begin
                                    sub_next   = byte_in;
                                    state_next = SUB_ACK;
                                end
                                default: begin
                                    state_next = DATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ADDR_ACK, SUB_ACK, DATA_ACK: begin
                    // First SCL fall after the 8th bit starts the ACK drive;
                    // the fall that ends the 9th clock releases it.
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                            if (state_reg == DATA_ACK) begin
                                wr_addr_next = sub_reg;
                                wr_data_next = shift_reg;
                                wr_stb_next  = 1'b1;
                                wr_done_next = 1'b1;
`ifdef I2C_TARGET_AUTO_INC_EN
                                sub_next     = 8'(sub_reg + 8'd1);
`endif
                            end
                        end else begin
                            sda_oe_next = 1'b0;
                            case (state_reg)
                                ADDR_ACK: state_next = SUB;
                                SUB_ACK:  state_next = DATA;
`ifdef I2C_TARGET_AUTO_INC_EN
                                default:  state_next = DATA;
`else
                                default:  state_next = IGNORE;
`endif
                            endcase
                        end
                    end
                end
                IDLE, IGNORE: begin
                end
                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Open-drain output; RESET gates the driver directly so the bus is
    // released in the same cycle reset is asserted.
    assign I2C_SDAT = (sda_oe_reg && RESET) ? 1'b0 : 1'bz;

    assign WR_ADDR = wr_addr_reg;
    assign WR_DATA = wr_data_reg;
    assign WR_STB  = wr_stb_reg;
    assign BUSY    = busy_reg;
    assign ERR     = err_reg;

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
//
// Bit-banged I2C master (SCL = CLOCK/16) driving i2c_target_rx. Expected
// ACKs, strobes, BUSY and ERR come from a byte-level model of the write
// protocol. Expected strobes are queued as bytes are sent, and a separate
// monitor pops and checks them whenever WR_STB is seen.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;

    localparam logic [6:0] DEV = 7'h1A;
    localparam int         SYNC = 2;
`ifdef I2C_TARGET_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    i2c_target_rx #(
        .DEV_ADDR    (DEV),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .WR_STB   (wr_stb),
        .BUSY     (busy),
        .ERR      (err)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_fall_cyc = 0;
    logic [7:0] tx [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write and arrive
    // 1+SYNC cycles after the SCL fall that ends the data byte.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && wr_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_stb_unexpected: got addr=%02h data=%02h, required no strobe",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), int'(e.a));
                check("wr_data", int'(wr_data), int'(e.d));
                check("stb_latency", cyc - last_fall_cyc, 1 + SYNC);
                $display("strobe addr=%02h data=%02h", wr_addr, wr_data);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bit-level tasks are entered at a negedge with SCL low.
    task automatic send_bit(input logic v, output logic sampled);
        wait_clk(4);
        sda_low = ~v;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        sampled = sda_bus;
        wait_clk(4);
        scl = 1'b0;
        last_fall_cyc = cyc;
    endtask

    task automatic start_cond();
        if (scl) begin
            wait_clk(4);
            sda_low = 1'b1;
            wait_clk(8);
        end else begin
            wait_clk(4);
            sda_low = 1'b0;
            wait_clk(4);
            scl = 1'b1;
            wait_clk(8);
            sda_low = 1'b1;
            wait_clk(8);
        end
        scl = 1'b0;
        last_fall_cyc = cyc;
    endtask

    task automatic stop_cond();
        wait_clk(4);
        sda_low = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);
        sda_low = 1'b0;
        wait_clk(16);
    endtask

    // Sends nbits of b MSB first; with a full byte also clocks the 9th bit
    // with SDA released and reports whether the target pulled it low.
    task automatic send_byte(input logic [7:0] b, input int nbits, output logic ack);
        logic s;
        ack = 1'b0;
        for (int i = 0; i < nbits; i++) send_bit(b[7-i], s);
        if (nbits == 8) begin
            send_bit(1'b1, s);
            ack = (s == 1'b0);
        end
    endtask

    // One transfer of n bytes from tx[], the last of which carries last_bits
    // bits, followed by STOP. Expectations follow the byte-level protocol:
    // the address byte is ACKed only on a write match, the sub-address and
    // the first data byte are ACKed after a match, later bytes only in a
    // burst build, and every ACKed data byte is a write to sub+index.
    task automatic run_txn(input int n, input int last_bits);
        logic match_w, match_r, exp_ack, ack;
        int   nb, strobes;
        logic exp_err;
        match_w = (tx[0][7:1] == DEV) && !tx[0][0];
        match_r = (tx[0][7:1] == DEV) &&  tx[0][0];
        strobes = 0;
        $display("txn addr=%02h n=%0d last_bits=%0d", tx[0], n, last_bits);
        start_cond();
        for (int k = 0; k < n; k++) begin
            nb = (k == n - 1) ? last_bits : 8;
            exp_ack = match_w && ((k <= 2) || AUTO_INC);
            if ((nb == 8) && (k >= 2) && exp_ack) begin
                exp_q.push_back('{a: 8'(tx[1] + 8'(k - 2)), d: tx[k]});
                strobes++;
            end
            send_byte(tx[k], nb, ack);
            if (nb == 8) check($sformatf("ack_byte%0d", k), int'(ack), int'(exp_ack));
            if (k == 0 && nb == 8) begin
                check("busy_after_addr", int'(busy), int'(match_w));
                check("err_after_addr", int'(err), int'(match_r));
            end
        end
        stop_cond();
        exp_err = match_r ||
                  (match_w && ((strobes == 0) || (AUTO_INC && (last_bits < 8) && (n - 1 >= 3))));
        check("busy_after_stop", int'(busy), 0);
        check("err_after_stop", int'(err), int'(exp_err));
        check("sda_released", int'(sda_bus), 1);
        check("strobes_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
    endtask

    initial begin
        #2ms;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic s;
        int   n, lb;
        rst_n   = 1'b0;
        scl     = 1'b1;
        sda_low = 1'b0;
        wait_clk(3);
        check("rst_wr_stb", int'(wr_stb), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_sda", int'(sda_bus), 1);
        rst_n = 1'b1;
        wait_clk(5);

        // Directed cases
        load4(8'h34, 8'h0E, 8'h42, 8'h00); run_txn(3, 8);
        load4(8'h36, 8'h0E, 8'h42, 8'h00); run_txn(3, 8);
        load4(8'h35, 8'h00, 8'h00, 8'h00); run_txn(1, 8);
        load4(8'h34, 8'h0E, 8'h42, 8'h00); run_txn(3, 8);
        load4(8'h34, 8'h0E, 8'hC3, 8'h00); run_txn(3, 4);
        load4(8'h34, 8'h05, 8'hAA, 8'hBB); run_txn(4, 8);
        load4(8'h34, 8'hFF, 8'h11, 8'h22); run_txn(4, 8);

        // Reset while the sub-address ACK is being driven
        start_cond();
        send_byte(8'h34, 8, ack);
        check("rst_case_addr_ack", int'(ack), 1);
        for (int i = 0; i < 8; i++) send_bit(tx[1][7-i], s);
        sda_low = 1'b0;
        wait_clk(5);
        check("sub_ack_driven", int'(sda_bus), 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sda", int'(sda_bus), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_err", int'(err), 0);
        check("rst_mid_wr_stb", int'(wr_stb), 0);
        check("rst_mid_wr_addr", int'(wr_addr), 0);
        check("rst_mid_wr_data", int'(wr_data), 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);
        load4(8'h34, 8'h21, 8'h5A, 8'h00); run_txn(3, 8);

        // Randomised transfers
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 5))
                0:       tx[0] = 8'h35;
                1:       tx[0] = 8'($urandom_range(0, 255));
                default: tx[0] = 8'h34;
            endcase
            for (int i = 1; i < 8; i++) tx[i] = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 5);
            lb = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            run_txn(n, lb);
        end

        wait_clk(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
